// File: rtl/conv_out_collector.sv
// -----------------------------------------------------------------------------
// conv_out_collector
//
// Collects one frame of signed convolution results and stores each one as an
// unsigned output pixel in an internal OUT_W*OUT_H memory. Each stored pixel
// is formed by ReLU, then a right shift, then saturation. The stored frame can
// be read back through a registered read port with a latency of one cycle.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous, active-low reset
//   start     one-cycle pulse that arms capture of one frame (IDLE/DONE only)
//   in_valid  result word valid from the convolution engine
//   in_data   signed conv result (DATA_W bits)
//   in_last   final result of the frame, qualified by in_valid
//   in_ready  collector accepts a word this cycle (CAPTURE only)
//   rd_en     readback request
//   rd_addr   readback address; addresses >= N read as 0
//   rd_data   registered readback pixel
//   busy      high in CAPTURE
//   done      high in DONE
//   err_len   frame length mismatch, meaningful while done=1
//   count     words accepted in the current or last frame
// -----------------------------------------------------------------------------
module conv_out_collector #(
    parameter int DATA_W = 20,
    parameter int PIX_W  = 8,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 6,
    parameter int OUT_H  = 6,
    parameter int N      = OUT_W * OUT_H,
    parameter int AW     = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic [PIX_W-1:0]         rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len,
    output logic [AW:0]              count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [AW-1:0]     LAST_ADDR = AW'(N - 1);
    localparam logic [DATA_W-1:0] PIX_MAX   = DATA_W'((2 ** PIX_W) - 1);

    // ReLU, shift, then clamp to the largest unsigned pixel value.
    function automatic logic [PIX_W-1:0] relu_sat(input logic signed [DATA_W-1:0] d);
        logic [DATA_W-1:0] v;
        v = $unsigned(d) >> SHIFT;
        if (d[DATA_W-1]) begin
            return '0;
        end
        if (v > PIX_MAX) begin
            return '1;
        end
        return v[PIX_W-1:0];
    endfunction

    logic [1:0]       state;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] mem [N];

    logic xfer;
    logic at_last;
    logic leave;

    // Outputs derive from the state register only, so in_ready has no
    // combinational path from in_valid.
    assign busy     = (state == S_CAPTURE);
    assign done     = (state == S_DONE);
    assign in_ready = busy;

    assign xfer    = in_valid & in_ready;
    assign at_last = (wr_addr == LAST_ADDR);
    assign leave   = xfer & (in_last | at_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            wr_addr <= '0;
            count   <= '0;
            err_len <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_CAPTURE;
                        wr_addr <= '0;
                        count   <= '0;
                        err_len <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (xfer) begin
                        wr_addr <= wr_addr + 1'b1;
                        count   <= count + 1'b1;
                    end
                    // A frame is only well formed when in_last lands exactly on
                    // the final address; any other exit flags a length error.
                    if (leave) begin
                        state   <= S_DONE;
                        err_len <= ~(in_last & at_last);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel memory has no reset; contents survive reset and idle periods.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_addr] <= relu_sat(in_data);
        end
    end

    // Nonblocking update of mem gives read-before-write on an address clash.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (rd_addr <= LAST_ADDR) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
module tb_conv_out_collector;

    localparam int DATA_W = 20;
    localparam int PIX_W  = 8;
    localparam int SHIFT  = 4;
    localparam int N      = 36;
    localparam int AW     = 6;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     in_ready;
    logic                     rd_en;
    logic [AW-1:0]            rd_addr;
    logic [PIX_W-1:0]         rd_data;
    logic                     busy;
    logic                     done;
    logic                     err_len;
    logic [AW:0]              count;

    conv_out_collector #(
        .DATA_W(DATA_W),
        .PIX_W (PIX_W),
        .SHIFT (SHIFT),
        .OUT_W (6),
        .OUT_H (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_last (in_last),
        .in_ready(in_ready),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err_len (err_len),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: what the frame should contain and report.
    int ref_mem [N];
    int m_cap  = 0;
    int m_addr = 0;
    int m_cnt  = 0;
    int m_done = 0;
    int m_err  = 0;

    typedef struct {
        int din;
        bit last;
        int exp;
    } vec_t;
    vec_t tbl [10];

    function automatic int ref_pix(input int d);
        int v;
        if (d < 0) return 0;
        v = d / (2 ** SHIFT);
        if (v > (2 ** PIX_W) - 1) return (2 ** PIX_W) - 1;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string nm);
        check({nm, ".busy"},    int'(busy),    m_cap);
        check({nm, ".done"},    int'(done),    m_done);
        check({nm, ".err_len"}, int'(err_len), m_err);
        check({nm, ".count"},   int'(count),   m_cnt);
    endtask

    task automatic model_arm;
        m_cap  = 1;
        m_addr = 0;
        m_cnt  = 0;
        m_done = 0;
        m_err  = 0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_cap == 0) model_arm();
    endtask

    // Presents one word for one clock edge; optionally pulses start with it.
    task automatic send_word(input int d, input bit last, input bit st);
        int cap0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_last  = last;
        start    = st;
        cap0     = m_cap;
        check("in_ready", int'(in_ready), cap0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        if (cap0 != 0) begin
            ref_mem[m_addr] = ref_pix(d);
            m_cnt++;
            if (last || m_addr == N - 1) begin
                m_cap  = 0;
                m_done = 1;
                m_err  = (last && m_addr == N - 1) ? 0 : 1;
            end
            m_addr++;
        end else if (st) begin
            model_arm();
        end
    endtask

    task automatic rd_check(input string nm, input int a, input int exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        check(nm, int'(rd_data), exp);
    endtask

    initial begin
        int d;
        int old;

        tbl[0] = '{-5,      1'b0, 0};
        tbl[1] = '{4095,    1'b0, 255};
        tbl[2] = '{4096,    1'b0, 255};
        tbl[3] = '{15,      1'b0, 0};
        tbl[4] = '{16,      1'b0, 1};
        tbl[5] = '{0,       1'b0, 0};
        tbl[6] = '{300,     1'b0, 18};
        tbl[7] = '{-524288, 1'b0, 0};
        tbl[8] = '{524287,  1'b0, 255};
        tbl[9] = '{100,     1'b1, 6};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        #1 rst = 1'b0;
        #1;
        check_status("reset");
        check("reset.in_ready", int'(in_ready), 0);
        check("reset.rd_data",  int'(rd_data),  0);
        tick();
        rst = 1'b1;
        tick();

        // Words offered before start are not consumed.
        in_valid = 1'b1;
        in_data  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_start.count",    int'(count),    0);
            check("pre_start.in_ready", int'(in_ready), 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        model_arm();
        check("armed.count",    int'(count),    0);
        check("armed.in_ready", int'(in_ready), 1);

        // Full frame, 16*k, in_last on the 36th word.
        for (int k = 0; k < N; k++) begin
            send_word(16 * k, k == N - 1, 1'b0);
            if (k == 0) check("first_xfer.count", int'(count), 1);
        end
        check_status("full");
        for (int k = 0; k < N; k++) rd_check("full.rd", k, k);

        // ReLU/saturation table, last on the 10th word -> short frame.
        do_start();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                old     = ref_mem[3];
                rd_en   = 1'b1;
                rd_addr = AW'(3);
                send_word(tbl[i].din, tbl[i].last, 1'b0);
                rd_en = 1'b0;
                check("rbw.rd_data", int'(rd_data), old);
            end else begin
                send_word(tbl[i].din, tbl[i].last, 1'b0);
            end
        end
        check_status("short");
        in_valid = 1'b1;
        in_data  = DATA_W'(4000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status("done_hold");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) rd_check("table.rd", i, tbl[i].exp);
        for (int i = 10; i < N; i++) rd_check("short.untouched", i, ref_mem[i]);

        // Random frame without in_last; start mid-frame must be ignored.
        do_start();
        for (int i = 0; i < N; i++) begin
            d = int'($urandom_range(0, 1048575)) - 524288;
            send_word(d, 1'b0, i == 5);
        end
        check_status("no_last");
        send_word(12345, 1'b1, 1'b0);
        check_status("no_last.37th");
        for (int i = 0; i < N; i++) rd_check("rand.rd", i, ref_mem[i]);
        rd_check("oob40", 40, 0);
        rd_check("oob63", 63, 0);
        rd_check("rd35", 35, ref_mem[35]);
        rd_addr = AW'(0);
        tick();
        tick();
        check("rd_hold", int'(rd_data), ref_mem[35]);

        // Asynchronous reset after 20 words of a frame.
        do_start();
        for (int k = 0; k < 20; k++) send_word(16 * (k + 1), 1'b0, 1'b0);
        check_status("mid_frame");
        rd_check("pre_reset.rd", 3, ref_mem[3]);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_cap  = 0;
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
        check_status("async_reset");
        check("async_reset.in_ready", int'(in_ready), 0);
        check("async_reset.rd_data",  int'(rd_data),  0);
        tick();
        rst = 1'b1;
        send_word(777, 1'b0, 1'b0);
        check_status("post_reset_idle");
        do_start();
        for (int k = 0; k < N; k++) send_word(16 * (N - 1 - k) + 7, k == N - 1, 1'b0);
        check_status("after_reset_full");
        for (int i = 0; i < N; i++) rd_check("after_reset.rd", i, ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_out_collector.md
CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 20, width of the signed convolution accumulator result.
REQ-002 SHALL have parameter PIX_W, default 8, width of the unsigned stored output pixel.
REQ-003 SHALL have parameter SHIFT, default 4, right-shift applied after ReLU.
REQ-004 SHALL have parameter OUT_W, default 6, output feature-map width.
REQ-005 SHALL have parameter OUT_H, default 6, output feature-map height; N = OUT_W*OUT_H, AW = clog2(N).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  single-cycle pulse that arms capture of one frame.
REQ-009 SHALL have port in_valid  input  1  result word valid from the convolution engine.
REQ-010 SHALL have port in_data  input  DATA_W  signed two's-complement conv result.
REQ-011 SHALL have port in_last  input  1  marks the final result of a frame; qualified by in_valid.
REQ-012 SHALL have port in_ready  output  1  collector accepts a word this cycle.
REQ-013 SHALL have port rd_en  input  1  readback request.
REQ-014 SHALL have port rd_addr  input  AW  readback address.
REQ-015 SHALL have port rd_data  output  PIX_W  registered readback pixel.
REQ-016 SHALL have port busy  output  1  high in CAPTURE.
REQ-017 SHALL have port done  output  1  high in DONE.
REQ-018 SHALL have port err_len  output  1  frame length mismatch flag, valid while done=1.
REQ-019 SHALL have port count  output  AW+1  number of words accepted in the current/last frame.

Function
REQ-020 SHALL implement FSM states IDLE, CAPTURE, DONE; reset state IDLE.
REQ-021 SHALL, in IDLE or DONE, on start=1 move to CAPTURE next cycle, clearing count, done, err_len and write address to 0.
REQ-022 SHALL ignore start while in CAPTURE.
REQ-023 SHALL drive in_ready=1 only in CAPTURE (state-derived, no combinational path from in_valid).
REQ-024 SHALL treat a transfer as in_valid & in_ready on a rising clk edge; each transfer writes one pixel and increments address and count by 1.
REQ-025 SHALL compute the stored pixel as: in_data<0 -> 0; else v = in_data >> SHIFT; v > 2^PIX_W-1 -> 2^PIX_W-1 (saturate); else v[PIX_W-1:0].
REQ-026 SHALL write the pixel to an internal N-entry memory at the current write address in the transfer cycle.
REQ-027 SHALL leave CAPTURE for DONE on the transfer carrying in_last=1 or on the transfer to address N-1, whichever comes first; no wrap-around, no further writes.
REQ-028 SHALL set err_len=1 on that exit transfer unless in_last=1 and address=N-1 coincide.
REQ-029 SHALL hold in_valid/in_data with no effect when in_ready=0 (words in IDLE/DONE are not consumed).
REQ-030 SHALL, on rd_en=1, load rd_data with mem[rd_addr] one cycle later (1-cycle latency) in any state; rd_addr >= N returns 0; rd_en=0 holds rd_data.
REQ-031 SHALL give a same-cycle read/write to the same address the old memory contents (read-before-write).
REQ-032 SHALL keep done=1, err_len and count stable in DONE until the next start.

Reset
REQ-033 SHALL, on rst=0, immediately force state IDLE, in_ready=0, busy=0, done=0, err_len=0, count=0, rd_data=0, write address 0, regardless of clk.
REQ-034 SHALL not clear memory contents on reset; reset mid-CAPTURE abandons the frame, and the collector needs a new start after rst returns high.

Verification
REQ-035 SHALL verify full frame: start, 36 words 16*k (k=0..35), in_last on the 36th -> done=1, err_len=0, count=36, readback addr k = k.
REQ-036 SHALL verify ReLU/saturation: in_data -5 -> 0, 4095 -> 255, 4096 -> 255, 15 -> 0, 16 -> 1.
REQ-037 SHALL verify short frame: in_last on the 10th word -> done=1, err_len=1, count=10, addr 10..35 unchanged.
REQ-038 SHALL verify backpressure: in_valid high before start -> no write, count=0; after start, first transfer one cycle later.
REQ-039 SHALL verify missing in_last: 36 words without in_last -> done after 36th, err_len=1; 37th word not accepted (in_ready=0).
REQ-040 SHALL verify async reset mid-frame after 20 words -> all outputs at reset values within the same cycle; new start then 36 words -> err_len=0.
